// File: rtl/lock_ctrl.sv
// Keypad door lock controller: four-digit BCD code entry, timed unlock window,
// error display, and in-place code reprogramming while the lock is open.
// Optional feature: define LOCK_CTRL_LOCKOUT_EN to enable the lockout state
// entered after MAX_FAILS consecutive wrong codes.
module lock_ctrl #(
    parameter logic [15:0] CODE_RESET    = 16'h1234,
    parameter int          UNLOCK_TICKS  = 250,
    parameter int          FAIL_TICKS    = 50,
    parameter int          LOCKOUT_TICKS = 500,
    parameter int          MAX_FAILS     = 3
) (
    input  logic        pulse_50Mhz,
    input  logic        reset,
    input  logic        tick_50hz,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] disp,
    output logic [3:0]  disp_blank,
    output logic [3:0]  led,
    output logic        led_g,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        FAIL     = 3'd4,
        LOCKOUT  = 3'd5,
        PROGRAM  = 3'd6
    } state_t;

    localparam int TMAX_A = (UNLOCK_TICKS > FAIL_TICKS) ? UNLOCK_TICKS : FAIL_TICKS;
    localparam int TMAX   = (TMAX_A > LOCKOUT_TICKS) ? TMAX_A : LOCKOUT_TICKS;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int FW     = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1);

    state_t         cur_state, nxt_state;
    logic [15:0]    entry, entry_n;
    logic [2:0]     count, count_n;
    logic [FW-1:0]  fail_cnt, fail_n, fail_inc;
    logic [TW-1:0]  timer, timer_n;
    logic [15:0]    code, code_n;
    logic [15:0]    disp_n;
    logic [3:0]     blank_n, led_n;
    logic           led_g_n;

    logic is_digit, is_clr, is_ent, is_prg, last_tick;

    assign state     = cur_state;
    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clr    = key_valid && (key_code == 4'hA);
    assign is_ent    = key_valid && (key_code == 4'hB);
    assign is_prg    = key_valid && (key_code == 4'hC);
    assign last_tick = tick_50hz && (timer == TW'(1));
    assign fail_inc  = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);

    // Next-state logic: key handling, timers, failure counting and code storage.
    always_comb begin
        nxt_state = cur_state;
        entry_n   = entry;
        count_n   = count;
        fail_n    = fail_cnt;
        timer_n   = timer;
        code_n    = code;
        case (cur_state)
            IDLE: begin
                if (is_digit) begin
                    entry_n   = {12'h0, key_code};
                    count_n   = 3'd1;
                    nxt_state = ENTRY;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    if (count < 3'd4) begin
                        entry_n = {entry[11:0], key_code};
                        count_n = count + 3'd1;
                    end
                end else if (is_clr) begin
                    entry_n   = 16'h0;
                    count_n   = 3'd0;
                    nxt_state = IDLE;
                end else if (is_ent) begin
                    if (count == 3'd4) begin
                        nxt_state = CHECK;
                    end else begin
                        entry_n   = 16'h0;
                        count_n   = 3'd0;
                        fail_n    = fail_inc;
                        timer_n   = TW'(FAIL_TICKS);
                        nxt_state = FAIL;
                    end
                end
            end
            CHECK: begin
                entry_n = 16'h0;
                count_n = 3'd0;
                if (entry == code) begin
                    fail_n    = '0;
                    timer_n   = TW'(UNLOCK_TICKS);
                    nxt_state = UNLOCKED;
                end else begin
                    fail_n    = fail_inc;
                    timer_n   = TW'(FAIL_TICKS);
                    nxt_state = FAIL;
                end
            end
            UNLOCKED: begin
                if (tick_50hz) timer_n = timer - TW'(1);
                if (is_clr) begin
                    nxt_state = IDLE;
                end else if (is_prg) begin
                    entry_n   = 16'h0;
                    count_n   = 3'd0;
                    nxt_state = PROGRAM;
                end else if (last_tick) begin
                    nxt_state = IDLE;
                end
            end
            FAIL: begin
                if (tick_50hz) timer_n = timer - TW'(1);
                if (last_tick) begin
`ifdef LOCK_CTRL_LOCKOUT_EN
                    if (fail_cnt == FW'(MAX_FAILS)) begin
                        timer_n   = TW'(LOCKOUT_TICKS);
                        nxt_state = LOCKOUT;
                    end else begin
                        nxt_state = IDLE;
                    end
`else
                    nxt_state = IDLE;
`endif
                end
            end
`ifdef LOCK_CTRL_LOCKOUT_EN
            LOCKOUT: begin
                if (tick_50hz) timer_n = timer - TW'(1);
                if (last_tick) begin
                    fail_n    = '0;
                    nxt_state = IDLE;
                end
            end
`endif
            PROGRAM: begin
                if (is_digit) begin
                    if (count < 3'd4) begin
                        entry_n = {entry[11:0], key_code};
                        count_n = count + 3'd1;
                    end
                end else if (is_ent && (count == 3'd4)) begin
                    code_n    = entry;
                    entry_n   = 16'h0;
                    count_n   = 3'd0;
                    timer_n   = TW'(UNLOCK_TICKS);
                    nxt_state = UNLOCKED;
                end else if (is_clr) begin
                    entry_n   = 16'h0;
                    count_n   = 3'd0;
                    timer_n   = TW'(UNLOCK_TICKS);
                    nxt_state = UNLOCKED;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Output decode from the next-state values so every output is registered.
    always_comb begin
        disp_n  = 16'h0;
        blank_n = 4'hF;
        led_n   = 4'h0;
        led_g_n = 1'b0;
        case (nxt_state)
            ENTRY, PROGRAM: begin
                disp_n = entry_n;
                for (int i = 0; i < 4; i++) begin
                    blank_n[i] = (count_n <= 3'(i));
                    led_n[i]   = (count_n > 3'(i));
                end
                led_g_n = (nxt_state == PROGRAM);
            end
            UNLOCKED: begin
                led_g_n = 1'b1;
            end
            FAIL: begin
                disp_n  = 16'hEEEE;
                blank_n = 4'h0;
            end
            LOCKOUT: begin
                disp_n  = 16'hFFFF;
                blank_n = 4'h0;
            end
            default: begin
                disp_n = 16'h0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge pulse_50Mhz) begin
        if (reset) begin
            cur_state  <= IDLE;
            entry      <= 16'h0;
            count      <= 3'd0;
            fail_cnt   <= '0;
            timer      <= '0;
            code       <= CODE_RESET;
            disp       <= 16'h0;
            disp_blank <= 4'hF;
            led        <= 4'h0;
            led_g      <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            entry      <= entry_n;
            count      <= count_n;
            fail_cnt   <= fail_n;
            timer      <= timer_n;
            code       <= code_n;
            disp       <= disp_n;
            disp_blank <= blank_n;
            led        <= led_n;
            led_g      <= led_g_n;
        end
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter CODE_RESET, default 16'h1234: code loaded at reset, four BCD nibbles, most significant nibble is the first digit.
REQ-002 Parameter UNLOCK_TICKS, default 250: length of the unlocked window, in tick_50hz pulses (5 s).
REQ-003 Parameter FAIL_TICKS, default 50: length of the error display, in ticks (1 s).
REQ-004 Parameter LOCKOUT_TICKS, default 500, and parameter MAX_FAILS, default 3: lockout length in ticks, and the consecutive-failure limit.
REQ-005 Port pulse_50Mhz, input, 1 bit: system clock; all logic is on the rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port tick_50hz, input, 1 bit: one-cycle strobe at 50 Hz from the divider.
REQ-008 Port key_valid, input, 1 bit: one-cycle strobe for a debounced key press.
REQ-009 Port key_code, input, 4 bits: 0-9 = digit, 0xA = CLR, 0xB = ENT, 0xC = PRG; every other code is ignored.
REQ-010 Port disp, output, 16 bits: four display nibbles; disp[15:12] is the leftmost digit.
REQ-011 Port disp_blank, output, 4 bits: per-digit blank; 1 = digit off; bit 3 is the leftmost digit.
REQ-012 Port led, output, 4 bits: led[i] = 1 when at least i+1 digits have been entered.
REQ-013 Port led_g, output, 1 bit: 1 while the lock is open.
REQ-014 Port state, output, 3 bits: state encoding, for debug.

Function
REQ-015 States SHALL be IDLE=0, ENTRY=1, CHECK=2, UNLOCKED=3, FAIL=4, LOCKOUT=5, PROGRAM=6; every output SHALL be registered.
REQ-016 IDLE: a digit key SHALL load entry to {12'h0, key}, set count to 1 and go to ENTRY; other keys SHALL be ignored.
REQ-017 ENTRY and PROGRAM, digit key: if count < 4, entry SHALL become {entry[11:0], key} and count SHALL increment; if count = 4, the key SHALL be ignored.
REQ-018 ENTRY: CLR SHALL clear entry and count and go to IDLE; ENT with count = 4 SHALL go to CHECK; ENT with count < 4 SHALL go to FAIL.
REQ-019 CHECK SHALL last exactly one cycle.
- entry = code: go to UNLOCKED and clear fail_cnt.
- Otherwise: go to FAIL.
REQ-020 On entry to FAIL, fail_cnt SHALL increment, saturating at MAX_FAILS.
REQ-021 FAIL display: disp = 16'hEEEE, disp_blank = 0.
REQ-022 FAIL exit: after FAIL_TICKS ticks, go to IDLE (for LOCKOUT behaviour see Configuration).
REQ-023 Timers: entering a timed state SHALL load the timer with N; each tick_50hz SHALL decrement it; the state SHALL exit on the tick that makes it 0, exactly N ticks after entry; a tick in the entry cycle SHALL not count.
REQ-024 UNLOCKED timing: led_g = 1; the state runs for UNLOCK_TICKS, then goes to IDLE.
REQ-025 UNLOCKED keys: CLR SHALL relock at once to IDLE; PRG SHALL go to PROGRAM with entry and count cleared.
REQ-026 UNLOCKED display: disp_blank = 4'hF.
REQ-027 PROGRAM: led_g = 1 and the timer SHALL be frozen.
- ENT with count = 4: code becomes entry, then go to UNLOCKED with the timer reloaded.
- ENT with count < 4: ignored.
- CLR: go to UNLOCKED with the code unchanged and the timer reloaded.
REQ-028 In ENTRY and PROGRAM, digits SHALL be right-justified: disp = entry; disp_blank[i] = 1 for i >= count.
REQ-029 In IDLE and CHECK: disp_blank = 4'hF; led = 0 outside ENTRY and PROGRAM.
REQ-030 If key_valid and tick_50hz occur in the same cycle, both SHALL be processed in that cycle.
REQ-031 A key that causes a state change SHALL take effect on the outputs in the next cycle.

Reset
REQ-032 Reset SHALL restore all state, whether or not an operation is in progress.
- state = IDLE; entry, count, fail_cnt and timer = 0; code = CODE_RESET.
- disp = 0, disp_blank = 4'hF, led = 0, led_g = 0.

Configuration
REQ-033 With macro LOCK_CTRL_LOCKOUT_EN defined:
- FAIL with fail_cnt = MAX_FAILS SHALL exit to LOCKOUT instead of IDLE.
- LOCKOUT SHALL ignore all keys, show disp = 16'hFFFF with disp_blank = 0, and last LOCKOUT_TICKS.
- LOCKOUT SHALL then go to IDLE and clear fail_cnt.
REQ-034 With LOCK_CTRL_LOCKOUT_EN undefined, LOCKOUT SHALL be unreachable and fail_cnt SHALL still saturate.

Verification
REQ-035 Correct code: after reset, keys 1,2,3,4 then ENT -> CHECK for one cycle, then led_g = 1; after 250 ticks, IDLE with led_g = 0.
REQ-036 Wrong code: keys 1,2,3,5 then ENT -> disp = 16'hEEEE for 50 ticks, then IDLE with fail_cnt = 1.
REQ-037 Short code: keys 7,8 then ENT -> FAIL; fifth digit after 1,2,3,4 -> ignored with led = 4'hF and disp = 16'h1234; CLR -> IDLE.
REQ-038 Change code: unlock, PRG, keys 9,8,7,6, ENT -> code becomes 16'h9876; code 1234 now fails and 9876 unlocks.
REQ-039 Lockout (macro defined): three wrong codes -> LOCKOUT, keys ignored for 500 ticks, then IDLE with fail_cnt = 0. Macro undefined: same stimulus -> IDLE after each FAIL.
REQ-040 Reset mid-entry: reset after keys 1,2 -> IDLE, disp_blank = 4'hF. Reset while UNLOCKED after a code change -> code = 16'h1234. Key and tick in the same cycle -> both processed.
